hypot_req_arbiter: RTL

//  Shares one iterative hypotenuse engine, sqrt(x^2+y^2), between NUM_REQ requesters.

---
 rtl/hypot_req_if.sv | 30 +++
 rtl/hypot_req_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/hypot_req_if.sv
// Requester-side job and response bundle for the hypotenuse arbiter.
// The master side is held by the requesters, the slave side by the arbiter.
interface hypot_req_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_x;
  logic [NUM_REQ*DW-1:0] req_y;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [DW-1:0]         rsp_root;
  logic                  rsp_err;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_root, rsp_err
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_root, rsp_err
  );
endinterface

// File: rtl/hypot_req_arbiter.sv
// Round-robin front end sharing one iterative hypotenuse engine,
// with a completion timeout and id-tagged responses.
module hypot_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 31
) (
  input  logic          clk,
  input  logic          rst,
  hypot_req_if.slave    bus,
  output logic          eng_start,
  output logic [DW-1:0] eng_x,
  output logic [DW-1:0] eng_y,
  input  logic          eng_done,
  input  logic [DW-1:0] eng_root,
  output logic          busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [TW-1:0]   timer;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] cand;
  logic            gnt_hit;

  // first valid requester after the last one served
  always_comb begin
    gnt_hit = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!gnt_hit && bus.req_valid[cand]) begin
        gnt_hit = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == S_IDLE && !rst && gnt_hit)
      bus.req_ready[gnt_id] = 1'b1;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      last_grant   <= ID_W'(NUM_REQ - 1);
      timer        <= '0;
      eng_start    <= 1'b0;
      eng_x        <= '0;
      eng_y        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id   <= '0;
      bus.rsp_root <= '0;
      bus.rsp_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (gnt_hit) begin
            eng_x      <= bus.req_x[gnt_id*DW +: DW];
            eng_y      <= bus.req_y[gnt_id*DW +: DW];
            bus.rsp_id <= gnt_id;
            eng_start  <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          eng_start <= 1'b0;
          timer     <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // a completion on the last allowed cycle still counts
          if (eng_done) begin
            bus.rsp_root  <= eng_root;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= S_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            bus.rsp_root  <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            last_grant    <= bus.rsp_id;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
